// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher
//   Hall-call scheduler for a two-car elevator bank. Hall up/down presses are
//   latched into per-floor call slots. A round-robin scan offers each pending
//   call to the nearest eligible car over a req/ack handshake. The call is
//   cleared when the owning car reports completion at that floor.
//
// Ports
//   CLK                     system clock, all state on posedge
//   RESET                   asynchronous active-low reset
//   hall_up[N_FLOORS]       up-call buttons (top floor bit ignored)
//   hall_dn[N_FLOORS]       down-call buttons (floor 0 bit ignored)
//   car0_pos / car1_pos     current floor of each car
//   car0_idle / car1_idle   car stopped, doors closed, no cab work
//   car0_ack / car1_ack     car accepts the offered assignment
//   car0_done / car1_done   one-cycle pulse: assigned floor served
//   car0_req / car1_req     assignment offer valid
//   car0_floor / car1_floor offered target floor
//   car0_dir / car1_dir     offered call direction (1 = up, 0 = down)
//   up_lamp / dn_lamp       hall lamps, high while the slot is not FREE
//   busy                    any slot not FREE
//
// Build option
//   OFFER_TIMEOUT_EN  an unacked offer is withdrawn after ACK_TIMEOUT cycles.
//                     The refusing car is then ineligible until its idle input
//                     drops and rises again.

module elevator_dispatcher #(
  parameter int unsigned N_FLOORS    = 4,
  parameter int unsigned FW          = 2,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_FLOORS-1:0] hall_up,
  input  logic [N_FLOORS-1:0] hall_dn,
  input  logic [FW-1:0]       car0_pos,
  input  logic [FW-1:0]       car1_pos,
  input  logic                car0_idle,
  input  logic                car1_idle,
  input  logic                car0_ack,
  input  logic                car1_ack,
  input  logic                car0_done,
  input  logic                car1_done,
  output logic                car0_req,
  output logic                car1_req,
  output logic [FW-1:0]       car0_floor,
  output logic [FW-1:0]       car1_floor,
  output logic                car0_dir,
  output logic                car1_dir,
  output logic [N_FLOORS-1:0] up_lamp,
  output logic [N_FLOORS-1:0] dn_lamp,
  output logic                busy
);

  localparam int unsigned NS = 2 * N_FLOORS;
  localparam int unsigned PW = FW + 1;

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_PEND  = 2'd1,
    S_ASGN0 = 2'd2,
    S_ASGN1 = 2'd3
  } slot_t;

  typedef enum logic {
    ST_SCAN  = 1'b0,
    ST_OFFER = 1'b1
  } fsm_t;

  function automatic logic [FW-1:0] f_slot_floor(input int unsigned idx);
    f_slot_floor = (idx < N_FLOORS) ? FW'(idx) : FW'(idx - N_FLOORS);
  endfunction

  slot_t          r_slot [NS];
  fsm_t           r_state;
  logic [PW-1:0]  r_ptr;
  logic           r_sel;
  logic           r_car0_req;
  logic           r_car1_req;
  logic [FW-1:0]  r_car0_floor;
  logic [FW-1:0]  r_car1_floor;
  logic           r_car0_dir;
  logic           r_car1_dir;

`ifdef OFFER_TIMEOUT_EN
  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [CW-1:0]  r_tmo_cnt;
  logic [1:0]     r_inelig;
`endif

  logic [NS-1:0]  w_press;
  logic [NS-1:0]  w_clr0;
  logic [NS-1:0]  w_clr1;
  logic           w_own0;
  logic           w_own1;
  logic           w_elig0;
  logic           w_elig1;
  logic [FW-1:0]  w_cur_floor;
  logic           w_cur_dir;
  logic           w_cur_pend;
  logic [FW:0]    w_d0;
  logic [FW:0]    w_d1;
  logic           w_pick1;
  logic [PW-1:0]  w_ptr_nxt;
  logic           w_ack;

  // Button vector in slot order; the unreachable directions are masked off.
  always_comb begin
    w_press               = {hall_dn, hall_up};
    w_press[N_FLOORS-1]   = 1'b0;
    w_press[N_FLOORS]     = 1'b0;
  end

  // Per-slot clear strobes and ownership. A slot being cleared this cycle no
  // longer counts as owned, so a car that completes its call becomes
  // eligible in the same cycle and the scan does not skip the next slot.
  always_comb begin
    w_clr0 = '0;
    w_clr1 = '0;
    w_own0 = 1'b0;
    w_own1 = 1'b0;
    for (int unsigned i = 0; i < NS; i++) begin
      w_clr0[i] = car0_done && (r_slot[i] == S_ASGN0) && (f_slot_floor(i) == car0_pos);
      w_clr1[i] = car1_done && (r_slot[i] == S_ASGN1) && (f_slot_floor(i) == car1_pos);
      if ((r_slot[i] == S_ASGN0) && !w_clr0[i]) w_own0 = 1'b1;
      if ((r_slot[i] == S_ASGN1) && !w_clr1[i]) w_own1 = 1'b1;
    end
  end

  always_comb begin
    w_elig0 = car0_idle && !w_own0 && !r_car0_req;
    w_elig1 = car1_idle && !w_own1 && !r_car1_req;
`ifdef OFFER_TIMEOUT_EN
    w_elig0 = w_elig0 && !r_inelig[0];
    w_elig1 = w_elig1 && !r_inelig[1];
`endif
  end

  always_comb begin
    w_cur_floor = f_slot_floor(32'(r_ptr));
    w_cur_dir   = (32'(r_ptr) < N_FLOORS);
    w_cur_pend  = (r_slot[r_ptr] == S_PEND);
    w_d0 = ({1'b0, car0_pos} >= {1'b0, w_cur_floor}) ?
           ({1'b0, car0_pos} - {1'b0, w_cur_floor}) :
           ({1'b0, w_cur_floor} - {1'b0, car0_pos});
    w_d1 = ({1'b0, car1_pos} >= {1'b0, w_cur_floor}) ?
           ({1'b0, car1_pos} - {1'b0, w_cur_floor}) :
           ({1'b0, w_cur_floor} - {1'b0, car1_pos});
    // Tie goes to car0.
    w_pick1   = w_elig1 && (!w_elig0 || (w_d1 < w_d0));
    w_ptr_nxt = (r_ptr == PW'(NS - 1)) ? '0 : r_ptr + 1'b1;
    w_ack     = r_sel ? (r_car1_req && car1_ack) : (r_car0_req && car0_ack);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NS; i++) r_slot[i] <= S_FREE;
      r_state      <= ST_SCAN;
      r_ptr        <= '0;
      r_sel        <= 1'b0;
      r_car0_req   <= 1'b0;
      r_car1_req   <= 1'b0;
      r_car0_floor <= '0;
      r_car1_floor <= '0;
      r_car0_dir   <= 1'b0;
      r_car1_dir   <= 1'b0;
`ifdef OFFER_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_inelig     <= '0;
`endif
    end else begin
      // Slot maintenance: a completion clear takes priority over a press.
      for (int unsigned i = 0; i < NS; i++) begin
        if (w_clr0[i] || w_clr1[i]) begin
          r_slot[i] <= S_FREE;
        end else if ((r_slot[i] == S_FREE) && w_press[i]) begin
          r_slot[i] <= S_PEND;
        end
      end

`ifdef OFFER_TIMEOUT_EN
      if (!car0_idle) r_inelig[0] <= 1'b0;
      if (!car1_idle) r_inelig[1] <= 1'b0;
`endif

      case (r_state)
        ST_SCAN: begin
          if (w_cur_pend && (w_elig0 || w_elig1)) begin
            r_state <= ST_OFFER;
            r_sel   <= w_pick1;
            if (w_pick1) begin
              r_car1_req   <= 1'b1;
              r_car1_floor <= w_cur_floor;
              r_car1_dir   <= w_cur_dir;
            end else begin
              r_car0_req   <= 1'b1;
              r_car0_floor <= w_cur_floor;
              r_car0_dir   <= w_cur_dir;
            end
`ifdef OFFER_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end else begin
            r_ptr <= w_ptr_nxt;
          end
        end

        ST_OFFER: begin
          if (w_ack) begin
            r_slot[r_ptr] <= r_sel ? S_ASGN1 : S_ASGN0;
            r_car0_req    <= 1'b0;
            r_car1_req    <= 1'b0;
            r_ptr         <= w_ptr_nxt;
            r_state       <= ST_SCAN;
          end
`ifdef OFFER_TIMEOUT_EN
          else if (r_tmo_cnt == CW'(ACK_TIMEOUT - 1)) begin
            // Withdraw the offer; the pointer stays so the slot is retried.
            r_car0_req      <= 1'b0;
            r_car1_req      <= 1'b0;
            r_inelig[r_sel] <= 1'b1;
            r_state         <= ST_SCAN;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        default: r_state <= ST_SCAN;
      endcase
    end
  end

  always_comb begin
    up_lamp = '0;
    dn_lamp = '0;
    for (int unsigned f = 0; f < N_FLOORS; f++) begin
      up_lamp[f] = (r_slot[f] != S_FREE);
      dn_lamp[f] = (r_slot[f + N_FLOORS] != S_FREE);
    end
  end

  assign busy       = |{up_lamp, dn_lamp};
  assign car0_req   = r_car0_req;
  assign car1_req   = r_car1_req;
  assign car0_floor = r_car0_floor;
  assign car1_floor = r_car1_floor;
  assign car0_dir   = r_car0_dir;
  assign car1_dir   = r_car1_dir;

endmodule
